// File: rtl/dram_stream_arbiter.sv
// dram_stream_arbiter: round-robin sharing of one DRAM command/response channel among streams
module dram_stream_arbiter #(
    parameter int NUM_STREAMS = 4,
    parameter int ADDR_W = 32,
    parameter int TAG_W = 32,
    parameter int DATA_W = 512,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_STREAMS-1:0]        req_valid,
    output logic [NUM_STREAMS-1:0]        req_ready,
    input  logic [NUM_STREAMS*ADDR_W-1:0] req_addr,
    input  logic [NUM_STREAMS-1:0]        req_isWr,
    input  logic [NUM_STREAMS*TAG_W-1:0]  req_tag,
    input  logic [NUM_STREAMS*DATA_W-1:0] req_wdata,
    output logic                          io_dram_cmd_valid,
    input  logic                          io_dram_cmd_ready,
    output logic [ADDR_W-1:0]             io_dram_cmd_bits_addr,
    output logic                          io_dram_cmd_bits_isWr,
    output logic [TAG_W-1:0]              io_dram_cmd_bits_tag,
    output logic [DATA_W-1:0]             io_dram_cmd_bits_wdata,
    output logic [31:0]                   io_dram_cmd_bits_streamId,
    input  logic                          io_dram_resp_valid,
    output logic                          io_dram_resp_ready,
    input  logic [DATA_W-1:0]             io_dram_resp_bits_rdata,
    input  logic [TAG_W-1:0]              io_dram_resp_bits_tag,
    input  logic [31:0]                   io_dram_resp_bits_streamId,
    output logic [NUM_STREAMS-1:0]        resp_valid,
    input  logic [NUM_STREAMS-1:0]        resp_ready,
    output logic [DATA_W-1:0]             resp_rdata,
    output logic [TAG_W-1:0]              resp_tag,
    output logic [NUM_STREAMS*8-1:0]      rd_outstanding,
    output logic                          err_sticky
);
    localparam int PW = $clog2(NUM_STREAMS);
    logic [PW-1:0] ptr, win, sidx, j;
    logic [PW:0] sum;
    logic full, found, grant, in_range, resp_hs;
    logic [NUM_STREAMS-1:0] elig;
    logic [7:0] cnt [NUM_STREAMS];
    always_comb begin
        for (int i = 0; i < NUM_STREAMS; i++) begin
            elig[i] = req_valid[i] & (req_isWr[i] | (cnt[i] < 8'(MAX_OUTSTANDING)));
            rd_outstanding[i*8 +: 8] = cnt[i];
        end
    end
    // Scan from the highest offset down so the stream closest to ptr wins.
    always_comb begin
        found = 1'b0;
        win = '0;
        sum = '0;
        j = '0;
        for (int k = NUM_STREAMS - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            j = (sum >= (PW+1)'(NUM_STREAMS)) ? PW'(sum - (PW+1)'(NUM_STREAMS)) : PW'(sum);
            if (elig[j]) begin
                found = 1'b1;
                win = j;
            end
        end
    end
    assign grant = found & (~full | io_dram_cmd_ready);
    assign io_dram_cmd_valid = full;
    assign sidx = io_dram_resp_bits_streamId[PW-1:0];
    assign in_range = io_dram_resp_bits_streamId < 32'(NUM_STREAMS);
    // Out-of-range responses are sunk so they cannot stall the shared channel.
    assign io_dram_resp_ready = ~in_range | resp_ready[sidx];
    assign resp_hs = io_dram_resp_valid & io_dram_resp_ready;
    assign resp_rdata = io_dram_resp_bits_rdata;
    assign resp_tag = io_dram_resp_bits_tag;
    always_comb begin
        for (int i = 0; i < NUM_STREAMS; i++) begin
            req_ready[i] = grant && win == PW'(i);
            resp_valid[i] = io_dram_resp_valid && in_range && sidx == PW'(i);
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            full <= 1'b0;
            ptr <= '0;
            err_sticky <= 1'b0;
            io_dram_cmd_bits_addr <= '0;
            io_dram_cmd_bits_isWr <= 1'b0;
            io_dram_cmd_bits_tag <= '0;
            io_dram_cmd_bits_wdata <= '0;
            io_dram_cmd_bits_streamId <= '0;
            cnt <= '{default: '0};
        end else begin
            full <= grant | (full & ~io_dram_cmd_ready);
            if (grant) begin
                ptr <= (win == PW'(NUM_STREAMS - 1)) ? '0 : win + 1'b1;
                io_dram_cmd_bits_streamId <= 32'(win);
            end
            if (resp_hs && (!in_range || cnt[sidx] == 8'd0)) err_sticky <= 1'b1;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                if (grant && win == PW'(i)) begin
                    io_dram_cmd_bits_addr <= req_addr[i*ADDR_W +: ADDR_W];
                    io_dram_cmd_bits_isWr <= req_isWr[i];
                    io_dram_cmd_bits_tag <= req_tag[i*TAG_W +: TAG_W];
                    io_dram_cmd_bits_wdata <= req_wdata[i*DATA_W +: DATA_W];
                end
                cnt[i] <= cnt[i] + 8'(grant && win == PW'(i) && !req_isWr[i])
                                 - 8'(resp_hs && in_range && sidx == PW'(i) && cnt[i] != 8'd0);
            end
        end
    end
endmodule

// File: tb/tb_dram_stream_arbiter.sv
// tb_dram_stream_arbiter: directed, table-driven and randomized checks of dram_stream_arbiter
module tb_dram_stream_arbiter;
    localparam int N = 4, AW = 32, TW = 32, DW = 512, MO = 8;
    logic clock = 1'b0, reset;
    logic [N-1:0] req_valid, req_ready, req_isWr, resp_valid, resp_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*TW-1:0] req_tag;
    logic [N*DW-1:0] req_wdata;
    logic cmd_valid, cmd_ready, cmd_isWr, dresp_valid, dresp_ready, err_sticky;
    logic [AW-1:0] cmd_addr;
    logic [TW-1:0] cmd_tag, dresp_tag, resp_tag;
    logic [DW-1:0] cmd_wdata, dresp_rdata, resp_rdata;
    logic [31:0] cmd_sid, dresp_sid;
    logic [N*8-1:0] rd_outstanding;

    dram_stream_arbiter #(.NUM_STREAMS(N), .ADDR_W(AW), .TAG_W(TW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_isWr(req_isWr),
        .req_tag(req_tag), .req_wdata(req_wdata),
        .io_dram_cmd_valid(cmd_valid), .io_dram_cmd_ready(cmd_ready),
        .io_dram_cmd_bits_addr(cmd_addr), .io_dram_cmd_bits_isWr(cmd_isWr),
        .io_dram_cmd_bits_tag(cmd_tag), .io_dram_cmd_bits_wdata(cmd_wdata),
        .io_dram_cmd_bits_streamId(cmd_sid),
        .io_dram_resp_valid(dresp_valid), .io_dram_resp_ready(dresp_ready),
        .io_dram_resp_bits_rdata(dresp_rdata), .io_dram_resp_bits_tag(dresp_tag),
        .io_dram_resp_bits_streamId(dresp_sid),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_tag(resp_tag),
        .rd_outstanding(rd_outstanding), .err_sticky(err_sticky)
    );

    always #5 clock = ~clock;

    int errors = 0, checks = 0;
    int m_ptr, m_cnt[N];
    bit m_full, m_err, m_isWr;
    logic [AW-1:0] m_addr;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_wdata;
    int m_sid;
    logic [N-1:0] last_rr, last_rv;
    logic last_ir;

    typedef struct {
        logic [31:0] sid;
        logic v;
        logic [N-1:0] rr;
        logic [N-1:0] exp_rv;
        logic exp_ir;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock: check combinational outputs against the model, clock, then check state.
    task automatic cycle();
        int w, sidi;
        bit in_r, ir, hs, n_wr;
        logic [AW-1:0] n_addr;
        logic [TW-1:0] n_tag;
        logic [DW-1:0] n_wdata;
        #1;
        w = -1;
        if (!m_full || cmd_ready)
            for (int k = 0; k < N; k++) begin
                int s;
                s = (m_ptr + k) % N;
                if (w < 0 && req_valid[s] && (req_isWr[s] || m_cnt[s] < MO)) w = s;
            end
        last_rr = req_ready;
        last_rv = resp_valid;
        last_ir = dresp_ready;
        chk("req_ready", 64'(req_ready), w >= 0 ? 64'(1) << w : 64'(0));
        in_r = dresp_sid < N;
        sidi = in_r ? int'(dresp_sid) : 0;
        ir = in_r ? resp_ready[sidi] : 1'b1;
        chk("resp_valid", 64'(resp_valid), (in_r && dresp_valid) ? 64'(1) << sidi : 64'(0));
        chk("io_resp_ready", 64'(dresp_ready), 64'(ir));
        chk("resp_fields", 64'(resp_rdata == dresp_rdata && resp_tag == dresp_tag), 64'(1));
        hs = dresp_valid && ir;
        n_addr = '0; n_tag = '0; n_wdata = '0; n_wr = 0;
        if (w >= 0) begin
            n_addr = req_addr[w*AW +: AW];
            n_tag = req_tag[w*TW +: TW];
            n_wdata = req_wdata[w*DW +: DW];
            n_wr = req_isWr[w];
        end
        @(posedge clock);
        #1;
        if (hs) begin
            if (!in_r || m_cnt[sidi] == 0) m_err = 1;
            else m_cnt[sidi]--;
        end
        if (w >= 0) begin
            m_full = 1; m_addr = n_addr; m_tag = n_tag; m_wdata = n_wdata; m_isWr = n_wr;
            m_sid = w; m_ptr = (w + 1) % N;
            if (!n_wr) m_cnt[w]++;
        end else if (cmd_ready) m_full = 0;
        chk("cmd_valid", 64'(cmd_valid), 64'(m_full));
        if (m_full) begin
            chk("cmd_addr", 64'(cmd_addr), 64'(m_addr));
            chk("cmd_tag", 64'(cmd_tag), 64'(m_tag));
            chk("cmd_isWr", 64'(cmd_isWr), 64'(m_isWr));
            chk("cmd_streamId", 64'(cmd_sid), 64'(m_sid));
            chk("cmd_wdata", 64'(cmd_wdata == m_wdata), 64'(1));
        end
        for (int i = 0; i < N; i++)
            chk($sformatf("rd_outstanding[%0d]", i), 64'(rd_outstanding[i*8 +: 8]), 64'(m_cnt[i]));
        chk("err_sticky", 64'(err_sticky), 64'(m_err));
    endtask

    task automatic do_reset();
        reset = 1; req_valid = '0; req_isWr = '0; cmd_ready = 0;
        dresp_valid = 0; dresp_sid = '0; resp_ready = '1;
        @(posedge clock);
        #1;
        reset = 0;
        m_full = 0; m_ptr = 0; m_err = 0; m_cnt = '{default: 0};
        chk("rst_cmd_valid", 64'(cmd_valid), 64'(0));
        chk("rst_cmd_addr", 64'(cmd_addr), 64'(0));
        chk("rst_cmd_streamId", 64'(cmd_sid), 64'(0));
        chk("rst_rd_outstanding", 64'(rd_outstanding), 64'(0));
        chk("rst_err_sticky", 64'(err_sticky), 64'(0));
    endtask

    task automatic randomize_data();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = $urandom;
            req_tag[i*TW +: TW] = $urandom;
        end
        for (int i = 0; i < N*DW/32; i++) req_wdata[i*32 +: 32] = $urandom;
        for (int i = 0; i < DW/32; i++) dresp_rdata[i*32 +: 32] = $urandom;
        dresp_tag = $urandom;
    endtask

    initial begin
        tbl[0] = '{32'd0, 1'b1, 4'b0001, 4'b0001, 1'b1};
        tbl[1] = '{32'd1, 1'b1, 4'b0001, 4'b0010, 1'b0};
        tbl[2] = '{32'd2, 1'b0, 4'b0100, 4'b0000, 1'b1};
        tbl[3] = '{32'd3, 1'b1, 4'b1000, 4'b1000, 1'b1};
        tbl[4] = '{32'd3, 1'b1, 4'b0111, 4'b1000, 1'b0};
        tbl[5] = '{32'd9, 1'b1, 4'b0000, 4'b0000, 1'b1};
        randomize_data();
        do_reset();
        foreach (tbl[t]) begin
            dresp_sid = tbl[t].sid; dresp_valid = tbl[t].v; resp_ready = tbl[t].rr;
            #1;
            chk($sformatf("tbl%0d_resp_valid", t), 64'(resp_valid), 64'(tbl[t].exp_rv));
            chk($sformatf("tbl%0d_io_resp_ready", t), 64'(dresp_ready), 64'(tbl[t].exp_ir));
            cycle();
            randomize_data();
        end

        // All streams reading, DRAM always ready: 0,1,2,3,0,... one per cycle
        do_reset();
        req_valid = '1; req_isWr = '0; cmd_ready = 1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_req_ready", 64'(last_rr), 64'(1) << (k % N));
            chk("rr_streamId", 64'(cmd_sid), 64'(k % N));
            chk("rr_cmd_valid", 64'(cmd_valid), 64'(1));
        end

        // Stream 2 blocked by DRAM backpressure: slot frozen
        do_reset();
        req_valid = 4'b0100; cmd_ready = 0;
        req_addr[2*AW +: AW] = 32'hA000_0002; req_tag[2*TW +: TW] = 32'h7A62;
        cycle();
        chk("blk_grant", 64'(last_rr), 64'(4'b0100));
        req_addr[2*AW +: AW] = 32'hBBBB_0002; req_tag[2*TW +: TW] = 32'h0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("blk_req_ready", 64'(last_rr), 64'(0));
            chk("blk_addr", 64'(cmd_addr), 64'(32'hA000_0002));
            chk("blk_tag", 64'(cmd_tag), 64'(32'h7A62));
        end
        cmd_ready = 1; req_valid = '0;
        cycle();
        chk("blk_drain", 64'(cmd_valid), 64'(0));

        // Outstanding-read cap on stream 1; writes bypass it
        do_reset();
        randomize_data();
        req_valid = 4'b0010; cmd_ready = 1;
        for (int k = 0; k < MO; k++) begin
            cycle();
            chk("cap_grant", 64'(last_rr), 64'(4'b0010));
        end
        chk("cap_count", 64'(rd_outstanding[15:8]), 64'(MO));
        cycle();
        chk("cap_block", 64'(last_rr), 64'(0));
        req_isWr = 4'b0010;
        cycle();
        chk("cap_write", 64'(last_rr), 64'(4'b0010));
        chk("cap_write_count", 64'(rd_outstanding[15:8]), 64'(MO));
        req_valid = '0; req_isWr = '0;
        dresp_valid = 1; dresp_sid = 32'd1;
        cycle();
        chk("cap_resp_count", 64'(rd_outstanding[15:8]), 64'(MO - 1));
        dresp_valid = 0; req_valid = 4'b0010;
        cycle();
        chk("cap_regrant", 64'(last_rr), 64'(4'b0010));

        // Response backpressure on stream 3
        do_reset();
        req_valid = 4'b1000; cmd_ready = 1;
        cycle();
        req_valid = '0; dresp_valid = 1; dresp_sid = 32'd3; resp_ready = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_resp_valid", 64'(last_rv), 64'(4'b1000));
            chk("bp_io_ready", 64'(last_ir), 64'(0));
            chk("bp_count", 64'(rd_outstanding[31:24]), 64'(1));
        end
        resp_ready = '1;
        cycle();
        chk("bp_hs_count", 64'(rd_outstanding[31:24]), 64'(0));

        // Grant and response for stream 0 together; then an out-of-range id
        dresp_valid = 0; req_valid = 4'b0001;
        cycle();
        dresp_valid = 1; dresp_sid = 32'd0;
        cycle();
        chk("same_grant", 64'(last_rr), 64'(4'b0001));
        chk("same_count", 64'(rd_outstanding[7:0]), 64'(1));
        req_valid = '0; dresp_sid = 32'd7;
        cycle();
        chk("oor_resp_valid", 64'(last_rv), 64'(0));
        chk("oor_io_ready", 64'(last_ir), 64'(1));
        chk("oor_err", 64'(err_sticky), 64'(1));

        // Reset with the slot full, counts nonzero and pointer moved
        dresp_valid = 0; req_valid = 4'b0010;
        cycle();
        do_reset();
        req_valid = '1; cmd_ready = 1;
        cycle();
        chk("rst_ptr_grant", 64'(last_rr), 64'(4'b0001));

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            randomize_data();
            req_valid = $urandom;
            req_isWr = $urandom & $urandom;
            cmd_ready = $urandom_range(0, 3) != 0;
            resp_ready = $urandom;
            dresp_valid = 0; dresp_sid = '0;
            if ($urandom_range(0, 15) == 0) begin
                dresp_valid = 1;
                dresp_sid = $urandom_range(0, 5);
                if (dresp_sid >= N) dresp_sid = dresp_sid + 32'd7;
            end else begin
                int s0;
                s0 = $urandom_range(0, N - 1);
                if (m_cnt[s0] > 0) begin
                    dresp_valid = $urandom_range(0, 1) == 1;
                    dresp_sid = s0;
                end
            end
            cycle();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dram_stream_arbiter.md
Name: dram_stream_arbiter

Overview:
- Shares the single Top DRAM command/response channel among NUM_STREAMS independent memory streams (load/store units).
- Round-robin arbitration of command requests into a registered command slot; stamps streamId with the winner index.
- Routes responses back to the owning stream by streamId.
- Enforces a per-stream cap on outstanding reads.

Parameters:
NUM_STREAMS, 4, number of requesting streams (2..16)
ADDR_W, 32, DRAM address width
TAG_W, 32, tag width, passed through untouched
DATA_W, 512, burst data width (16 x 32-bit words, word 0 in bits [31:0])
MAX_OUTSTANDING, 8, max reads in flight per stream (1..255)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
req_valid  in  NUM_STREAMS  per-stream command valid
req_ready  out  NUM_STREAMS  per-stream command accept (one-hot or zero)
req_addr  in  NUM_STREAMS*ADDR_W  per-stream address, stream i at slice i
req_isWr  in  NUM_STREAMS  1 = write, 0 = read
req_tag  in  NUM_STREAMS*TAG_W  per-stream tag
req_wdata  in  NUM_STREAMS*DATA_W  per-stream write data
io_dram_cmd_valid  out  1  command slot occupied
io_dram_cmd_ready  in  1  DRAM accepts command
io_dram_cmd_bits_addr / _isWr / _tag / _wdata  out  ADDR_W / 1 / TAG_W / DATA_W  registered winner fields
io_dram_cmd_bits_streamId  out  32  winner index, zero-extended
io_dram_resp_valid  in  1  response valid
io_dram_resp_ready  out  1  response accept
io_dram_resp_bits_rdata / _tag / _streamId  in  DATA_W / TAG_W / 32  response fields
resp_valid  out  NUM_STREAMS  per-stream response valid
resp_ready  in  NUM_STREAMS  per-stream response accept
resp_rdata / resp_tag  out  DATA_W / TAG_W  shared response fields (broadcast)
rd_outstanding  out  NUM_STREAMS*8  per-stream in-flight read count
err_sticky  out  1  protocol error seen, cleared only by reset

Behaviour:
- Reset (synchronous): io_dram_cmd_valid=0, all cmd bits 0, RR pointer=0, all rd_outstanding=0, err_sticky=0. Reset mid-operation discards the occupied slot without issuing it.
- Slot states:
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY on cmd handshake with no new grant.
  - FULL -> FULL on handshake plus new grant in the same cycle (refill).
  - io_dram_cmd_valid = FULL. Slot contents are stable while valid and not ready.
- Eligibility of stream i: req_valid[i] and (req_isWr[i] or rd_outstanding[i] < MAX_OUTSTANDING).
- Grant enable: slot EMPTY or io_dram_cmd_ready=1.
- Grant selection: first eligible stream scanning pointer, pointer+1, ... (mod NUM_STREAMS). req_ready = one-hot winner when grant enable is set, otherwise 0. req_ready may depend combinationally on req_valid.
- Pointer update: on grant, pointer <= winner+1 (mod NUM_STREAMS). Otherwise unchanged.
- Latency: request accepted in cycle T -> io_dram_cmd_valid in T+1. With io_dram_cmd_ready held at 1, sustains 1 command/cycle.
- Counters: rd_outstanding[i] increments when a read from i is granted (at grant, not at DRAM accept). It decrements on a response handshake with streamId=i. Both in the same cycle -> unchanged. Writes are not counted and receive no response.
- Response routing, combinational with no storage:
  - s = io_dram_resp_bits_streamId. resp_valid[s] = io_dram_resp_valid; all others 0.
  - io_dram_resp_ready = resp_ready[s].
  - resp_rdata/resp_tag = io_dram_resp fields.
- Out-of-range streamId (>= NUM_STREAMS): response is sunk (io_dram_resp_ready=1, no resp_valid), err_sticky <= 1.
- Response for stream with rd_outstanding=0: delivered normally, counter stays 0 (no underflow), err_sticky <= 1.
- Counter saturation is structurally impossible because eligibility blocks reads at MAX_OUTSTANDING.

Test Plan:
- All 4 streams assert reads continuously, io_dram_cmd_ready=1 -> streamIds issued 0,1,2,3,0,... one per cycle; first cmd_valid one cycle after first req_ready.
- Stream 2 read only, io_dram_cmd_ready=0 for 5 cycles -> cmd_valid high with addr/tag frozen for 5 cycles; req_ready[2]=0 while blocked; exactly one command issued after ready rises.
- Stream 1 issues 8 reads, no responses -> rd_outstanding[1]=8; 9th read not granted; stream 1 write still granted; one response with streamId=1 -> count 7, next read granted.
- Response streamId=3, resp_ready[3]=0 for 3 cycles -> resp_valid[3]=1, io_dram_resp_ready=0 for 3 cycles; counter decrements only on the handshake cycle.
- Read grant and response for the same stream in the same cycle -> count unchanged. Response streamId=7 -> sunk, err_sticky=1.
- Reset asserted with slot FULL and counts nonzero -> next cycle cmd_valid=0, counts 0, pointer 0, err_sticky 0.
